ddr_wr_arbiter: RTL and testbench
=================================

# ddr_wr_arbiter

Shares the single DDR3 controller write port among REQ_NUM upstream 32-to-128-bit TS packers. Each packer pushes {address, 128-bit data} words into a private show-ahead FIFO. A round-robin scheduler drains the FIFOs onto the DDR3 user interface, running the command and write-data handshakes independently. The block sits between the packers and the DDR3 controller user port.

## Interface
- REQ_NUM, 4: number of upstream packers.
- DDR3_ADDR_WIDTH, 28: width of the DDR3 user address.
- FIFO_DEPTH_BIT, 4: log2 of the per-requester FIFO depth (16 words).
- U_DLY, 1: simulation delay on register assignments.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_addr  in  REQ_NUM*DDR3_ADDR_WIDTH  per-requester address; requester k occupies slice k.
- req_data  in  REQ_NUM*128  per-requester write data; requester k occupies slice k.
- req_valid  in  REQ_NUM  per-requester push strobe, 1-cycle pulses.
- req_afull  out  REQ_NUM  FIFO k holds at least depth-2 words.
- req_ovf  out  REQ_NUM  sticky: a push arrived while FIFO k was full.
- ovf_clr  in  1  clears all req_ovf bits.
- app_cmd  out  3  fixed at 3'b000 (write).
- app_cmd_en  out  1  command valid.
- app_addr  out  DDR3_ADDR_WIDTH  command address.
- app_rdy  in  1  controller accepts the command.
- app_wdf_data  out  128  write data.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (one beat per burst).
- app_wdf_rdy  in  1  controller accepts the write data.
- grant_id  out  log2(REQ_NUM)  requester whose word is currently presented.

## Operation
- **Push:** a push to requester k writes into FIFO k when it is not full. A push to a full FIFO is dropped and sets req_ovf[k].
- **Overflow flags:** if ovf_clr and a new overflow occur in the same cycle, the new overflow wins and the bit stays 1.
- **States:**
  - IDLE: nothing presented.
  - ISSUE: a word is presented.
- **IDLE → ISSUE:** in IDLE, if any FIFO is non-empty, select the first non-empty index searching upward from last_grant+1 modulo REQ_NUM. Pop that FIFO, register its addr and data onto the app_* outputs, set grant_id, and go to ISSUE.
- **Handshake flags:** ISSUE tracks two flags, cmd_done and wdf_done, both cleared when a word is loaded.
  - app_cmd_en = ISSUE and not cmd_done. cmd_done sets on app_cmd_en and app_rdy.
  - app_wdf_wren = ISSUE and not wdf_done. wdf_done sets on app_wdf_wren and app_wdf_rdy.
- **Completion:** a word completes in the cycle where both handshakes are satisfied, counting the current cycle's acceptances. On completion, last_grant takes the value of grant_id.
  - If any FIFO is non-empty, arbitrate again in the same cycle, load the next word and stay in ISSUE (back-to-back).
  - Otherwise go to IDLE.
- **Word integrity:** address and data never change while either handshake is still pending.
- **Same-cycle push and pop** on the same FIFO are both performed; the occupancy count is unchanged.
- **Pop on empty** never happens, because the pop is gated by the non-empty check.

## Timing
- **Reset:**
  - All FIFOs empty; state IDLE.
  - last_grant = REQ_NUM-1, so requester 0 wins first.
  - app_cmd_en, app_wdf_wren, app_wdf_end = 0.
  - app_addr, app_wdf_data, grant_id = 0; req_ovf = 0; req_afull = 0.
- **Latency:** a push at cycle n on an idle block gives app_cmd_en and app_wdf_wren high at cycle n+2.
- **Throughput:** one word per cycle when the controller holds both ready signals high.
- **Flag timing:** req_afull and req_ovf are registered and update one cycle after the causing push or pop.
- **Reset mid-transfer:** an in-flight word and all FIFO contents are discarded. Outputs return to their reset values the cycle after rst is sampled.

## Structure
- A shared package ddr_wr_pkg holds DDR_CMD_WRITE (3'b000), the data width (128) and the FIFO depth constant.
- Sub-module ddr_wr_fifo: synchronous show-ahead FIFO with write enable, read enable, empty, full and almost-full. It is instantiated REQ_NUM times in a generate loop.
- The round-robin selector is a combinational function inside ddr_wr_arbiter.

## Test plan
- **Single word:** reset, then push addr 0x0000100 / data 0xA5...A5 on requester 2 with app_rdy = app_wdf_rdy = 1. Expect app_cmd_en and app_wdf_wren high exactly one cycle, two cycles after the push, with grant_id = 2 and app_wdf_end = 1.
- **Round robin:** all four requesters push one word in the same cycle. Expect grant order 0, 1, 2, 3 on consecutive cycles; a second round of pushes is served 0, 1, 2, 3 again.
- **Decoupled handshake:** app_rdy high at cycle 0, app_wdf_rdy low until cycle 3. Expect app_cmd_en to drop after cycle 0, app_wdf_wren held until cycle 3, and the next word loaded at cycle 4 with addr and data stable throughout.
- **Overflow:** with app_rdy = 0, push 17 words to requester 1. Expect req_afull[1] after the 14th push and req_ovf[1] = 1 after the 17th. The 17th word is never issued; ovf_clr clears the flag.
- **Reset mid-operation:** assert rst while ISSUE is pending with 5 words queued. Expect all outputs at reset values, and no stale word issued after rst deasserts.

Source files
------------

// File: rtl/ddr_wr_pkg.sv
// Shared constants and types for the DDR3 write-port arbiter.
package ddr_wr_pkg;

  localparam logic [2:0] DDR_CMD_WRITE     = 3'b000;
  localparam int         DDR_DATA_W        = 128;
  localparam int         WR_FIFO_DEPTH_BIT = 4;
  localparam int         WR_FIFO_DEPTH     = 1 << WR_FIFO_DEPTH_BIT;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } arb_state_t;

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// DDR3 controller user-port write signals; master drives command/data, slave returns ready.
interface ddr_wr_arbiter_if import ddr_wr_pkg::*; #(
  parameter int DDR3_ADDR_WIDTH = 28
);
  logic [2:0]                 app_cmd;
  logic                       app_cmd_en;
  logic [DDR3_ADDR_WIDTH-1:0] app_addr;
  logic                       app_rdy;
  logic [DDR_DATA_W-1:0]      app_wdf_data;
  logic                       app_wdf_wren;
  logic                       app_wdf_end;
  logic                       app_wdf_rdy;

  modport master (
    output app_cmd, app_cmd_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy
  );

  modport slave (
    input  app_cmd, app_cmd_en, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy
  );
endinterface

// File: rtl/ddr_wr_fifo.sv
// Synchronous show-ahead FIFO: rd_dat presents the oldest word whenever not empty.
// Writes to a full FIFO and reads from an empty one are ignored; afull is registered.
module ddr_wr_fifo import ddr_wr_pkg::*; #(
  parameter int WIDTH     = 156,
  parameter int DEPTH_BIT = WR_FIFO_DEPTH_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full,
  output logic             afull
);
  localparam int                 DEPTH     = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] CNT_ONE   = (DEPTH_BIT+1)'(1);
  localparam logic [DEPTH_BIT:0] CNT_FULL  = (DEPTH_BIT+1)'(DEPTH);
  localparam logic [DEPTH_BIT:0] CNT_AFULL = (DEPTH_BIT+1)'(DEPTH - 2);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_BIT-1:0] wr_ptr;
  logic [DEPTH_BIT-1:0] rd_ptr;
  logic [DEPTH_BIT:0]   count;
  logic [DEPTH_BIT:0]   count_nxt;
  logic                 wr_ok;
  logic                 rd_ok;

  assign empty  = (count == '0);
  assign full   = (count == CNT_FULL);
  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_en & ~empty;
  assign rd_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)
      count_nxt = count + CNT_ONE;
    else if (rd_ok && !wr_ok)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      afull  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      afull <= (count_nxt >= CNT_AFULL);
    end
  end

  // Storage needs no reset: the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin drain of REQ_NUM per-packer FIFOs onto the DDR3 write port.
// Command and write-data handshakes complete independently; next word loads on completion.
module ddr_wr_arbiter import ddr_wr_pkg::*; #(
  parameter int REQ_NUM         = 4,
  parameter int DDR3_ADDR_WIDTH = 28,
  parameter int FIFO_DEPTH_BIT  = WR_FIFO_DEPTH_BIT,
  localparam int ID_W           = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [REQ_NUM*DDR3_ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM*DDR_DATA_W-1:0]      req_data,
  input  logic [REQ_NUM-1:0]                 req_valid,
  output logic [REQ_NUM-1:0]                 req_afull,
  output logic [REQ_NUM-1:0]                 req_ovf,
  input  logic                               ovf_clr,
  ddr_wr_arbiter_if.master                   app,
  output logic [ID_W-1:0]                    grant_id
);
  localparam int AW      = DDR3_ADDR_WIDTH;
  localparam int ENTRY_W = AW + DDR_DATA_W;

  logic [REQ_NUM-1:0]    fifo_empty;
  logic [REQ_NUM-1:0]    fifo_full;
  logic [REQ_NUM-1:0]    fifo_pop;
  logic [ENTRY_W-1:0]    fifo_dat [REQ_NUM];

  arb_state_t            state;
  logic                  cmd_en;
  logic                  wren;
  logic [AW-1:0]         addr_q;
  logic [DDR_DATA_W-1:0] data_q;
  logic [ID_W-1:0]       last_grant;

  logic                  complete;
  logic                  load;
  logic [ID_W-1:0]       eff_last;
  logic [ID_W-1:0]       pick;

  for (genvar k = 0; k < REQ_NUM; k++) begin : g_fifo
    ddr_wr_fifo #(
      .WIDTH     (ENTRY_W),
      .DEPTH_BIT (FIFO_DEPTH_BIT)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (req_valid[k]),
      .wr_dat ({req_addr[k*AW +: AW], req_data[k*DDR_DATA_W +: DDR_DATA_W]}),
      .rd_en  (fifo_pop[k]),
      .rd_dat (fifo_dat[k]),
      .empty  (fifo_empty[k]),
      .full   (fifo_full[k]),
      .afull  (req_afull[k])
    );
  end

  // First non-empty index at or after last+1, wrapping; last itself has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [REQ_NUM-1:0] ne,
                                              input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] sel;
    int              idx;
    sel = '0;
    for (int i = REQ_NUM; i >= 1; i--) begin
      idx = (int'(last) + i) % REQ_NUM;
      if (ne[idx]) sel = ID_W'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    complete = (state == ST_ISSUE) && (!cmd_en || app.app_rdy) && (!wren || app.app_wdf_rdy);
    load     = (|(~fifo_empty)) && ((state == ST_IDLE) || complete);
    eff_last = complete ? grant_id : last_grant;
    pick     = rr_pick(~fifo_empty, eff_last);
    fifo_pop = '0;
    if (load) fifo_pop[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_en     <= 1'b0;
      wren       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(REQ_NUM - 1);
    end else begin
      if (cmd_en && app.app_rdy)     cmd_en <= 1'b0;
      if (wren && app.app_wdf_rdy)   wren   <= 1'b0;
      if (complete)                  last_grant <= grant_id;
      if (load) begin
        state            <= ST_ISSUE;
        cmd_en           <= 1'b1;
        wren             <= 1'b1;
        {addr_q, data_q} <= fifo_dat[pick];
        grant_id         <= pick;
      end else if (complete) begin
        state <= ST_IDLE;
      end
    end
  end

  // A new overflow in the same cycle as ovf_clr keeps its bit set.
  always_ff @(posedge clk) begin
    if (rst)
      req_ovf <= '0;
    else
      req_ovf <= (ovf_clr ? '0 : req_ovf) | (req_valid & fifo_full);
  end

  assign app.app_cmd      = DDR_CMD_WRITE;
  assign app.app_cmd_en   = cmd_en;
  assign app.app_addr     = addr_q;
  assign app.app_wdf_data = data_q;
  assign app.app_wdf_wren = wren;
  assign app.app_wdf_end  = wren;

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Directed bench for ddr_wr_arbiter: latency, round robin, split handshakes, overflow, reset.
module tb_ddr_wr_arbiter;
  import ddr_wr_pkg::*;

  localparam int RN = 4;
  localparam int AW = 28;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [RN*AW-1:0]     req_addr;
  logic [RN*128-1:0]    req_data;
  logic [RN-1:0]        req_valid;
  logic [RN-1:0]        req_afull;
  logic [RN-1:0]        req_ovf;
  logic                 ovf_clr;
  logic [1:0]           grant_id;

  int vectors     = 0;
  int miscompares = 0;

  ddr_wr_arbiter_if #(.DDR3_ADDR_WIDTH(AW)) app ();

  ddr_wr_arbiter #(
    .REQ_NUM         (RN),
    .DDR3_ADDR_WIDTH (AW),
    .FIFO_DEPTH_BIT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_afull (req_afull),
    .req_ovf   (req_ovf),
    .ovf_clr   (ovf_clr),
    .app       (app),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_req(input int k, input logic [AW-1:0] a, input logic [127:0] d);
    req_addr[k*AW +: AW]   = a;
    req_data[k*128 +: 128] = d;
    req_valid[k]           = 1'b1;
  endtask

  task automatic chk_word(input string tag, input int g, input logic [AW-1:0] a,
                          input logic [127:0] d);
    chk({tag, "_cmd_en"}, app.app_cmd_en, 1'b1);
    chk({tag, "_wren"},   app.app_wdf_wren, 1'b1);
    chk({tag, "_end"},    app.app_wdf_end, 1'b1);
    chk({tag, "_cmd"},    app.app_cmd, 3'b000);
    chk({tag, "_grant"},  grant_id, g);
    chk({tag, "_addr"},   app.app_addr, a);
    chk({tag, "_data"},   app.app_wdf_data, d);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd_en"}, app.app_cmd_en, 1'b0);
    chk({tag, "_wren"},   app.app_wdf_wren, 1'b0);
    chk({tag, "_end"},    app.app_wdf_end, 1'b0);
    chk({tag, "_addr"},   app.app_addr, '0);
    chk({tag, "_data"},   app.app_wdf_data, '0);
    chk({tag, "_grant"},  grant_id, '0);
    chk({tag, "_afull"},  req_afull, '0);
    chk({tag, "_ovf"},    req_ovf, '0);
  endtask

  initial begin
    req_addr         = '0;
    req_data         = '0;
    req_valid        = '0;
    ovf_clr          = 1'b0;
    app.app_rdy      = 1'b1;
    app.app_wdf_rdy  = 1'b1;
    rst              = 1'b1;
    tick();
    tick();
    chk_reset_outs("reset");
    rst = 1'b0;
    tick();

    // Single word on requester 2: visible two cycles after the push, for one cycle.
    load_req(2, 28'h0000100, {16{8'hA5}});
    tick();
    req_valid = '0;
    chk("single_n1_cmd_en", app.app_cmd_en, 1'b0);
    tick();
    chk_word("single", 2, 28'h0000100, {16{8'hA5}});
    tick();
    chk("single_after_cmd_en", app.app_cmd_en, 1'b0);
    chk("single_after_wren", app.app_wdf_wren, 1'b0);

    // Round robin from a fresh reset: two rounds both served 0,1,2,3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < RN; k++) load_req(k, AW'(32'h200 + 16 * r + k), 128'(k + 1));
      tick();
      req_valid = '0;
      tick();
      for (int k = 0; k < RN; k++) begin
        chk_word($sformatf("rr%0d_%0d", r, k), k, AW'(32'h200 + 16 * r + k), 128'(k + 1));
        tick();
      end
      chk($sformatf("rr%0d_idle", r), app.app_cmd_en, 1'b0);
    end

    // Split handshakes: command accepted at cycle 0, data accepted at cycle 3.
    app.app_wdf_rdy = 1'b0;
    load_req(0, 28'h0000300, 128'h3333_0000);
    load_req(1, 28'h0000301, 128'h3333_0001);
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("split_c%0d_cmd_en", c), app.app_cmd_en, (c == 0));
      chk($sformatf("split_c%0d_wren", c), app.app_wdf_wren, 1'b1);
      chk($sformatf("split_c%0d_grant", c), grant_id, 2'd0);
      chk($sformatf("split_c%0d_addr", c), app.app_addr, 28'h0000300);
      chk($sformatf("split_c%0d_data", c), app.app_wdf_data, 128'h3333_0000);
      if (c == 3) app.app_wdf_rdy = 1'b1;
      tick();
    end
    chk_word("split_c4", 1, 28'h0000301, 128'h3333_0001);
    tick();
    chk("split_idle", app.app_cmd_en, 1'b0);

    // Overflow: park a requester-0 word on the port so requester 1 fills its FIFO.
    app.app_rdy     = 1'b0;
    app.app_wdf_rdy = 1'b0;
    load_req(0, 28'h0000400, 128'hDEAD);
    tick();
    req_valid = '0;
    tick();
    chk_word("park", 0, 28'h0000400, 128'hDEAD);
    for (int i = 0; i < 17; i++) begin
      load_req(1, AW'(32'h500 + i), 128'(i));
      tick();
      chk($sformatf("ovf_push%0d_afull", i + 1), req_afull, {2'b00, (i + 1 >= 14), 1'b0});
      chk($sformatf("ovf_push%0d_ovf", i + 1), req_ovf, {2'b00, (i + 1 >= 17), 1'b0});
    end
    req_valid = '0;
    load_req(1, 28'h00005FF, 128'hFF);
    ovf_clr = 1'b1;
    tick();
    req_valid = '0;
    chk("ovf_clr_vs_new", req_ovf, 4'b0010);
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", req_ovf, 4'b0000);

    app.app_rdy     = 1'b1;
    app.app_wdf_rdy = 1'b1;
    chk_word("drain_park", 0, 28'h0000400, 128'hDEAD);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk_word($sformatf("drain%0d", i), 1, AW'(32'h500 + i), 128'(i));
      tick();
    end
    chk("drain_idle", app.app_cmd_en, 1'b0);
    chk("drain_afull", req_afull, 4'b0000);

    // Reset while a word is pending and five more are queued.
    app.app_rdy     = 1'b0;
    app.app_wdf_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_req(3, AW'(32'h600 + i), 128'(i + 16'h60));
      tick();
    end
    req_valid = '0;
    chk("midrst_pending", app.app_cmd_en, 1'b1);
    chk("midrst_grant", grant_id, 2'd3);
    rst = 1'b1;
    tick();
    chk_reset_outs("midrst");
    rst             = 1'b0;
    app.app_rdy     = 1'b1;
    app.app_wdf_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midrst_stale%0d", c), app.app_cmd_en, 1'b0);
    end
    load_req(0, 28'h0000700, 128'h77);
    tick();
    req_valid = '0;
    tick();
    chk_word("postrst", 0, 28'h0000700, 128'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
